// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and default parameters for the UART receive sequencer
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, FERR, LOAD} state_t;
  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_DATA_BITS = 8;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: mod-N cycle counter with synchronous clear and a terminal-count flag
module bit_timer #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!n_rst || clr_i) cnt_q <= '0;
    else cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
  end
  assign cnt_o = cnt_q;
  assign tc_o = cnt_q == W'(N - 1);
endmodule

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: UART receive sequencing (start validation, bit strobes, stop check, buffer handshake).
// Even parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_sequencer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic parity_error,
  output logic busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  state_t state_q, state_d;
  logic prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic framing_q, framing_d, ready_q, ready_d, overrun_q, overrun_d;
  logic [TW-1:0] timer;
  logic tc, timer_clr;
`ifdef UART_RX_PARITY_EN
  logic acc_q, acc_d, parity_q, parity_d;
`endif
  // Restart the bit period on every state change so each state times from zero
  assign timer_clr = (state_q == IDLE) || (state_d != state_q);
  bit_timer #(.N(CLKS_PER_BIT), .W(TW)) u_timer (
    .clk(clk), .n_rst(n_rst), .clr_i(timer_clr), .cnt_o(timer), .tc_o(tc)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    framing_d = framing_q;
    ready_d = data_read ? 1'b0 : ready_q;
    overrun_d = data_read ? 1'b0 : overrun_q;
`ifdef UART_RX_PARITY_EN
    acc_d = acc_q;
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: if (prev_q && !serial_in) state_d = START;
      START: if (timer == HALF_M1) begin
        if (!serial_in) begin
          state_d = DATA;
          cnt_d = '0;
          framing_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          acc_d = 1'b0;
          parity_d = 1'b0;
`endif
        end else state_d = IDLE;
      end
      DATA: if (tc) begin
        cnt_d = cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        acc_d = acc_q ^ serial_in;
        if (cnt_q == LAST_BIT) state_d = PARITY;
`else
        if (cnt_q == LAST_BIT) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tc) begin
        parity_d = acc_q ^ serial_in;
        state_d = STOP;
      end
`endif
      STOP: if (tc) begin
        state_d = serial_in ? LOAD : FERR;
        if (!serial_in) framing_d = 1'b1;
      end
      FERR: if (serial_in) state_d = IDLE;
      LOAD: begin
        state_d = IDLE;
        ready_d = 1'b1;
        if (ready_q && !data_read) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      prev_q <= 1'b1;
      cnt_q <= '0;
      framing_q <= 1'b0;
      ready_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= serial_in;
      cnt_q <= cnt_d;
      framing_q <= framing_d;
      ready_q <= ready_d;
      overrun_q <= overrun_d;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      parity_q <= parity_d;
    end
  end
  assign parity_error = parity_q;
`else
  assign parity_error = 1'b0;
`endif
  assign shift_strobe = (state_q == DATA) && tc;
  assign load_buffer = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign data_ready = ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;
endmodule
